// File: rtl/reg_scoreboard_pkg.sv
// Shared scoreboard types and sizing constants, also used by the hazard and decode logic.
package sb_pkg;

  localparam int SB_NREG        = 32;
  localparam int SB_ISSUE_PORTS = 2;
  localparam int SB_WB_PORTS    = 2;
  localparam int SB_LAT_W       = 3;
  localparam int SB_REG_W       = $clog2(SB_NREG);

  typedef logic [SB_LAT_W-1:0] sb_lat_t;
  typedef logic [SB_REG_W-1:0] sb_reg_t;

  // isVar marks a result owned by a variable-latency unit (cleared by writeback, not by countdown)
  typedef struct packed {
    logic    busy;
    logic    isVar;
    sb_lat_t cnt;
  } sb_entry_t;

endpackage

// File: rtl/reg_scoreboard_entry.sv
// Per-register in-flight tracker: fixed-latency countdown or variable-latency wait for writeback.
module sb_entry
  import sb_pkg::*;
#(
  parameter int LAT_W = SB_LAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [LAT_W-1:0] setLat,
  input  logic             clear,
  input  logic             flush,
  output logic             busy,
  output logic             ready
);

  typedef struct packed {
    logic             busy;
    logic             isVar;
    logic [LAT_W-1:0] cnt;
  } entry_t;

  entry_t state;

  // Writebacks only affect variable entries; a fixed entry ignores them and keeps counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '0;
    end else if (flush) begin
      state <= '0;
    end else if (set) begin
      state.busy  <= 1'b1;
      state.isVar <= (setLat == '0);
      state.cnt   <= setLat;
    end else if (state.busy && state.isVar) begin
      if (clear) begin
        state <= '0;
      end
    end else if (state.busy) begin
      state.cnt <= state.cnt - LAT_W'(1);
      if (state.cnt == LAT_W'(1)) begin
        state.busy <= 1'b0;
      end
    end
  end

  assign busy  = state.busy;
  assign ready = !state.busy || (!state.isVar && state.cnt == LAT_W'(1));

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: in-order multi-port issue permission plus set/clear decode into per-register entries.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NREG        = SB_NREG,
  parameter int ISSUE_PORTS = SB_ISSUE_PORTS,
  parameter int WB_PORTS    = SB_WB_PORTS,
  parameter int LAT_W       = SB_LAT_W,
  localparam int RW         = $clog2(NREG)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ISSUE_PORTS-1:0]             iss_valid,
  input  logic [ISSUE_PORTS-1:0][RW-1:0]     iss_rs1,
  input  logic [ISSUE_PORTS-1:0][RW-1:0]     iss_rs2,
  input  logic [ISSUE_PORTS-1:0]             iss_rs1_en,
  input  logic [ISSUE_PORTS-1:0]             iss_rs2_en,
  input  logic [ISSUE_PORTS-1:0][RW-1:0]     iss_rd,
  input  logic [ISSUE_PORTS-1:0][LAT_W-1:0]  iss_lat,
  output logic [ISSUE_PORTS-1:0]             iss_ok,
  input  logic [WB_PORTS-1:0]                wb_valid,
  input  logic [WB_PORTS-1:0][RW-1:0]        wb_rd,
  input  logic                               flush,
  output logic [NREG-1:0]                    busy_vec,
  output logic                               idle
);

  logic [NREG-1:0]             busyInt;
  logic [NREG-1:0]             readyVec;
  logic [NREG-1:1]             setEn;
  logic [NREG-1:1]             clearEn;
  logic [NREG-1:1][LAT_W-1:0]  setLatVec;
  logic                        chainOk;
  logic                        portOk;

  assign busyInt[0]  = 1'b0;
  assign readyVec[0] = 1'b1;

  // A port issues only if every older port issues too, so hazards against all lower ports are checked.
  always_comb begin
    iss_ok  = '0;
    chainOk = !flush;
    portOk  = 1'b0;
    for (int p = 0; p < ISSUE_PORTS; p++) begin
      portOk = iss_valid[p] && chainOk;
      if (iss_rs1_en[p] && !readyVec[iss_rs1[p]]) portOk = 1'b0;
      if (iss_rs2_en[p] && !readyVec[iss_rs2[p]]) portOk = 1'b0;
      if (iss_rd[p] != '0 && busyInt[iss_rd[p]])   portOk = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (iss_rd[q] != '0) begin
          if (iss_rs1_en[p] && iss_rs1[p] == iss_rd[q]) portOk = 1'b0;
          if (iss_rs2_en[p] && iss_rs2[p] == iss_rd[q]) portOk = 1'b0;
          if (iss_rd[p] == iss_rd[q])                   portOk = 1'b0;
        end
      end
      iss_ok[p] = portOk;
      chainOk   = portOk;
    end
  end

  // Intra-cycle WAW blocking guarantees at most one issuing port targets a given register.
  always_comb begin
    setEn     = '0;
    setLatVec = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int p = 0; p < ISSUE_PORTS; p++) begin
        if (iss_ok[p] && iss_rd[p] == RW'(r)) begin
          setEn[r]     = 1'b1;
          setLatVec[r] = iss_lat[p];
        end
      end
    end
  end

  always_comb begin
    clearEn = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k] && wb_rd[k] == RW'(r)) clearEn[r] = 1'b1;
      end
    end
  end

  for (genvar r = 1; r < NREG; r++) begin : gEntry
    sb_entry #(.LAT_W(LAT_W)) uEntry (
      .clk    (clk),
      .reset  (reset),
      .set    (setEn[r]),
      .setLat (setLatVec[r]),
      .clear  (clearEn[r]),
      .flush  (flush),
      .busy   (busyInt[r]),
      .ready  (readyVec[r])
    );
  end

  assign busy_vec = busyInt;
  assign idle     = ~|busyInt;

endmodule
